// File: rtl/hash_target_cmp_mc.sv
// Multi-lane Blake2b target comparator: per-lane h0 compare, lowest-lane winner capture,
// result held until host ack, with a saturating count of hits dropped while holding.
module hash_target_cmp_mc #(
  parameter int unsigned LANES = 4,
  parameter int unsigned CW = 8,
  parameter logic [63:0] IV = 64'h6a09e667f2bdc928,
  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                in_valid,
  input  logic [64*LANES-1:0] in_v0,
  input  logic [64*LANES-1:0] in_v8,
  input  logic [64*LANES-1:0] in_m04,
  input  logic [63:0]         target,
  input  logic                res_ack,
  output logic                busy,
  output logic                found,
  output logic [31:0]         nonce,
  output logic [LW-1:0]       lane,
  output logic [CW-1:0]       drop_cnt
);

  typedef enum logic [1:0] {StIdle, StSearch, StHold} state_e;

  state_e state;

  logic [LANES-1:0] hit_d, hit_q;
  logic [31:0]      lnonce_d [LANES];
  logic [31:0]      lnonce_q [LANES];
  logic             v1_q;
  logic             start_acc;
  logic             win;
  logic [LW-1:0]    win_idx;
  logic [31:0]      win_nonce;

  function automatic logic [63:0] bswap64(input logic [63:0] x);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) begin
      r[8*(7-b)+:8] = x[8*b+:8];
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      hit_d[i] = in_valid &
                 (bswap64(IV ^ in_v0[64*i+:64] ^ in_v8[64*i+:64]) < target);
      lnonce_d[i] = {in_m04[64*i+:8], in_m04[64*i+8+:8],
                     in_m04[64*i+16+:8], in_m04[64*i+24+:8]};
    end
  end

  assign start_acc = (state == StIdle) && start && !abort;

  // Accepting a new job flushes whatever is sitting in stage 1 from the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      hit_q <= '0;
      for (int i = 0; i < LANES; i++) lnonce_q[i] <= '0;
    end else begin
      v1_q  <= in_valid && !start_acc;
      hit_q <= hit_d;
      for (int i = 0; i < LANES; i++) lnonce_q[i] <= lnonce_d[i];
    end
  end

  // Descending scan so the lowest hitting lane is the last assignment.
  always_comb begin
    win_idx   = '0;
    win_nonce = lnonce_q[0];
    for (int i = LANES - 1; i >= 0; i--) begin
      if (hit_q[i]) begin
        win_idx   = LW'(i);
        win_nonce = lnonce_q[i];
      end
    end
    win = v1_q && (|hit_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      busy     <= 1'b0;
      found    <= 1'b0;
      nonce    <= '0;
      lane     <= '0;
      drop_cnt <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start_acc) begin
            state    <= StSearch;
            busy     <= 1'b1;
            drop_cnt <= '0;
          end
        end
        StSearch: begin
          if (abort) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else if (win) begin
            state <= StHold;
            busy  <= 1'b0;
            found <= 1'b1;
            nonce <= win_nonce;
            lane  <= win_idx;
          end
        end
        StHold: begin
          if (win && (drop_cnt != {CW{1'b1}})) drop_cnt <= drop_cnt + CW'(1);
          if (res_ack || abort) begin
            state <= StIdle;
            found <= 1'b0;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
          found <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_target_cmp_mc.sv
// Scoreboard bench for hash_target_cmp_mc: stimulus pushes expected results, a negedge
// monitor pops and checks them on each rising edge of found.
module tb_hash_target_cmp_mc;

  localparam int unsigned LANES = 4;
  localparam int unsigned CW = 8;
  localparam logic [63:0] IV = 64'h6a09e667f2bdc928;

  logic                clk = 1'b0;
  logic                rst, start, abort, in_valid, res_ack;
  logic [64*LANES-1:0] in_v0, in_v8, in_m04;
  logic [63:0]         target;
  logic                busy, found;
  logic [31:0]         nonce;
  logic [1:0]          lane;
  logic [CW-1:0]       drop_cnt;

  hash_target_cmp_mc #(.LANES(LANES), .CW(CW), .IV(IV)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
    .in_v0(in_v0), .in_v8(in_v8), .in_m04(in_m04), .target(target), .res_ack(res_ack),
    .busy(busy), .found(found), .nonce(nonce), .lane(lane), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] nonce;
    logic [1:0]  lane;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  logic found_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] bswap(input logic [63:0] x);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[63-8*b-:8] = x[8*b+:8];
    return r;
  endfunction

  // Chooses v0 so that the lane's byte-swapped h0 equals sw.
  task automatic set_lane(input int i, input logic [63:0] sw, input logic [31:0] n);
    in_v0[64*i+:64]  = IV ^ bswap(sw);
    in_v8[64*i+:64]  = 64'h0;
    in_m04[64*i+:64] = {32'h0, n};
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < LANES; i++) set_lane(i, 64'hffff_ffff_ffff_ffff, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] n, input logic [1:0] l);
    exp_t e;
    e.nonce = n;
    e.lane  = l;
    exp_q.push_back(e);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (found && !found_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_found", 64'(found), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_nonce", 64'(nonce), 64'(e.nonce));
        check("sb_lane", 64'(lane), 64'(e.lane));
        check("sb_busy", 64'(busy), 64'(0));
      end
    end
    found_prev = found;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; res_ack = 1'b0;
    target = 64'h100;
    clear_lanes();
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_found", 64'(found), 64'(0));
    check("rst_nonce", 64'(nonce), 64'(0));
    check("rst_lane", 64'(lane), 64'(0));
    check("rst_drop", 64'(drop_cnt), 64'(0));

    // 1: single hit on lane 2, two-cycle latency
    do_start();
    check("t1_busy", 64'(busy), 64'(1));
    set_lane(2, 64'h1, 32'h11223344);
    push(32'h44332211, 2'd2);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    clear_lanes();
    check("t1_found_t1", 64'(found), 64'(0));
    tick();
    check("t1_found_t2", 64'(found), 64'(1));
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    check("t1_ack_found", 64'(found), 64'(0));
    check("t1_ack_busy", 64'(busy), 64'(0));

    // 2: equal and target+1 are misses
    do_start();
    set_lane(0, 64'h100, 32'h1);
    set_lane(1, 64'h101, 32'h2);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    clear_lanes();
    tick(); tick();
    check("t2_found", 64'(found), 64'(0));
    check("t2_busy", 64'(busy), 64'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t2_abort_busy", 64'(busy), 64'(0));

    // 3: lanes 1 and 3 together, lane 1 wins
    do_start();
    set_lane(1, 64'h5, 32'hA1B2C3D4);
    set_lane(3, 64'h7, 32'h55667788);
    push(32'hD4C3B2A1, 2'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    clear_lanes();
    tick();
    check("t3_found", 64'(found), 64'(1));
    check("t3_drop", 64'(drop_cnt), 64'(0));

    // 4: hits while holding saturate drop_cnt
    set_lane(0, 64'h0, 32'h99999999);
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check("t4_drop_9", 64'(drop_cnt), 64'(9));
    for (int k = 0; k < 290; k++) tick();
    in_valid = 1'b0;
    clear_lanes();
    tick(); tick();
    check("t4_drop_sat", 64'(drop_cnt), 64'(255));
    check("t4_nonce", 64'(nonce), 64'hD4C3B2A1);
    check("t4_lane", 64'(lane), 64'(1));
    check("t4_found", 64'(found), 64'(1));
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    check("t4_ack_found", 64'(found), 64'(0));

    // 5: abort on the win cycle wins, no capture
    do_start();
    check("t5_drop_clr", 64'(drop_cnt), 64'(0));
    set_lane(0, 64'h1, 32'hDEADBEEF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    clear_lanes();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy", 64'(busy), 64'(0));
    check("t5_found", 64'(found), 64'(0));
    check("t5_nonce", 64'(nonce), 64'hD4C3B2A1);
    set_lane(2, 64'h0, 32'h12345678);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    clear_lanes();
    tick(); tick();
    check("t5_idle_found", 64'(found), 64'(0));
    check("t5_idle_drop", 64'(drop_cnt), 64'(0));

    // 6: rst in HOLD, then a normal job
    do_start();
    set_lane(2, 64'h3, 32'h01020304);
    push(32'h04030201, 2'd2);
    in_valid = 1'b1;
    tick();
    clear_lanes();
    set_lane(0, 64'h0, 32'h0);
    tick();
    check("t6_found", 64'(found), 64'(1));
    tick(); tick();
    in_valid = 1'b0;
    clear_lanes();
    tick();
    check("t6_drop", 64'(drop_cnt), 64'(3));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_found", 64'(found), 64'(0));
    check("t6_rst_nonce", 64'(nonce), 64'(0));
    check("t6_rst_lane", 64'(lane), 64'(0));
    check("t6_rst_drop", 64'(drop_cnt), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    do_start();
    check("t6_busy", 64'(busy), 64'(1));
    set_lane(3, 64'h0, 32'hCAFEF00D);
    push(32'h0DF0FECA, 2'd3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    clear_lanes();
    tick();
    check("t6_found2", 64'(found), 64'(1));
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    tick();
    check("sb_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
